// File: rtl/div_8_by_4_seq.sv
// rtl/div_8_by_4_seq.sv - sequential restoring divider, 8-bit dividend by 4-bit divisor
// One quotient bit per cycle; operands and result move over valid/ready handshakes.
module div_8_by_4_seq #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  prem_q, prem_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W:0]    trial_diff;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    prem_d     = prem_q;
    dsr_d      = dsr_q;
    dbz_d      = dbz_q;
    // Shift the next dividend bit into the partial remainder and try a subtract.
    trial      = {prem_q, quo_q[DIVIDEND_W-1]};
    trial_diff = trial - {1'b0, dsr_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dsr_d = divisor;
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            prem_d  = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            quo_d   = dividend;
            prem_d  = '0;
          end
        end
      end

      BUSY: begin
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
        if (trial >= {1'b0, dsr_q}) begin
          // Restored result is always below the divisor, so it fits in DIVISOR_W bits.
          prem_d   = trial_diff[DIVISOR_W-1:0];
          quo_d[0] = 1'b1;
        end else begin
          prem_d = trial[DIVISOR_W-1:0];
        end
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = DONE;
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      prem_q  <= '0;
      dsr_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      prem_q  <= prem_d;
      dsr_q   <= dsr_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = prem_q;
  assign div_by_zero = dbz_q;

endmodule
